// File: rtl/pcileech_eth_pkg.sv
// Shared types, constants and CRC-32 step function for the ETH RMII paths.
package pcileech_eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_ABORT,
    ST_IFG
  } eth_tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
  localparam logic [31:0] ETH_CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC32_INIT    = 32'hFFFFFFFF;

  // Reflected CRC-32 advanced by one dibit; d[0] is the earlier bit on the wire.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ ETH_CRC32_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [1:0] dibit_sel(input logic [7:0] b, input logic [1:0] idx);
    return b[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/pcileech_eth_crc32_d2.sv
// Registered CRC-32 engine consuming one RMII dibit per clock; shared by TX and RX.
module pcileech_eth_crc32_d2
  import pcileech_eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  d,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= ETH_CRC32_INIT;
    else if (init) crc <= ETH_CRC32_INIT;
    else if (en)   crc <= crc32_dibit(crc, d);
  end

endmodule

// File: rtl/pcileech_eth_rmii_tx.sv
// RMII MAC transmit framer: preamble/SFD, optional pad (PCILEECH_ETH_TX_PAD_EN),
// CRC-32 FCS and inter-frame gap, one dibit per 50 MHz clock.
module pcileech_eth_rmii_tx
  import pcileech_eth_pkg::*;
#(
  parameter int PARAM_PREAMBLE_BYTES = 7,
  parameter int PARAM_IFG_BYTES      = 12,
  parameter int PARAM_MIN_FRAME      = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       eth_tx_en,
  output logic [1:0] eth_tx_data,
  output logic       tx_busy,
  output logic       tx_underrun
);

`ifdef PCILEECH_ETH_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int          IFG_CYC  = PARAM_IFG_BYTES * 4;
  localparam logic [10:0] MIN_CNT  = 11'(PARAM_MIN_FRAME);
  localparam logic [15:0] PRE_LAST = 16'(PARAM_PREAMBLE_BYTES - 1);
  // The IDLE cycle that samples tx_valid is the last gap cycle, so IFG itself is one short.
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYC - 2);

  eth_tx_state_t state, state_n;
  logic [1:0]  dc;
  logic [15:0] sub_cnt, sub_cnt_n;
  logic [10:0] byte_cnt;
  logic [7:0]  cur_byte;
  logic        last_seen;
  logic [1:0]  dibit;
  logic        crc_init, crc_en;
  logic [31:0] crc, fcs;
  logic        active, accept, pad_byte;

  pcileech_eth_crc32_d2 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .d     (dibit),
    .crc   (crc)
  );

  assign fcs         = ~crc;
  assign active      = (state == ST_PRE) || (state == ST_SFD) || (state == ST_DATA) ||
                       (state == ST_PAD) || (state == ST_FCS);
  assign accept      = tx_ready & tx_valid;
  assign pad_byte    = (state == ST_PAD) && (dc == 2'd3);
  assign tx_busy     = (state != ST_IDLE);
  assign tx_underrun = (state == ST_ABORT);

  always_comb begin
    state_n   = state;
    sub_cnt_n = sub_cnt;
    tx_ready  = 1'b0;
    dibit     = 2'b00;
    crc_init  = 1'b0;
    crc_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        crc_init  = 1'b1;
        sub_cnt_n = '0;
        if (tx_valid) state_n = ST_PRE;
      end
      ST_PRE: begin
        dibit = dibit_sel(ETH_PREAMBLE_BYTE, dc);
        if (dc == 2'd3) begin
          if (sub_cnt >= PRE_LAST) begin
            sub_cnt_n = '0;
            state_n   = ST_SFD;
          end else begin
            sub_cnt_n = sub_cnt + 16'd1;
          end
        end
      end
      ST_SFD: begin
        dibit = dibit_sel(ETH_SFD_BYTE, dc);
        if (dc == 2'd3) begin
          tx_ready = 1'b1;
          state_n  = tx_valid ? ST_DATA : ST_ABORT;
        end
      end
      ST_DATA: begin
        dibit  = dibit_sel(cur_byte, dc);
        crc_en = 1'b1;
        if (dc == 2'd3) begin
          if (last_seen) begin
            state_n = (PAD_EN && (byte_cnt < MIN_CNT)) ? ST_PAD : ST_FCS;
          end else begin
            tx_ready = 1'b1;
            state_n  = tx_valid ? ST_DATA : ST_ABORT;
          end
        end
      end
`ifdef PCILEECH_ETH_TX_PAD_EN
      ST_PAD: begin
        crc_en = 1'b1;
        if ((dc == 2'd3) && (byte_cnt >= MIN_CNT - 11'd1)) state_n = ST_FCS;
      end
`endif
      ST_FCS: begin
        dibit = fcs[{sub_cnt[1:0], dc, 1'b0} +: 2];
        if (dc == 2'd3) begin
          if (sub_cnt[1:0] == 2'd3) begin
            sub_cnt_n = '0;
            state_n   = ST_IFG;
          end else begin
            sub_cnt_n = sub_cnt + 16'd1;
          end
        end
      end
      ST_ABORT: begin
        // The abort cycle already counts toward the gap.
        sub_cnt_n = 16'd1;
        state_n   = ST_IFG;
      end
      ST_IFG: begin
        if (sub_cnt >= IFG_LAST) begin
          sub_cnt_n = '0;
          state_n   = ST_IDLE;
        end else begin
          sub_cnt_n = sub_cnt + 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dc          <= 2'd0;
      sub_cnt     <= '0;
      byte_cnt    <= '0;
      cur_byte    <= '0;
      last_seen   <= 1'b0;
      eth_tx_en   <= 1'b0;
      eth_tx_data <= 2'b00;
    end else begin
      state       <= state_n;
      sub_cnt     <= sub_cnt_n;
      dc          <= active ? dc + 2'd1 : 2'd0;
      eth_tx_en   <= active;
      eth_tx_data <= active ? dibit : 2'b00;
      if (state == ST_IDLE) begin
        byte_cnt  <= '0;
        last_seen <= 1'b0;
      end else begin
        if ((accept || pad_byte) && (byte_cnt != 11'h7FF)) byte_cnt <= byte_cnt + 11'd1;
        if (accept) begin
          cur_byte  <= tx_data;
          last_seen <= tx_last;
        end
      end
    end
  end

endmodule

// File: doc/pcileech_eth_rmii_tx.md
Name: pcileech_eth_rmii_tx

Overview:
- RMII MAC transmit framer: takes a byte stream from the UDP/com layer and drives 2-bit RMII dibits to the PHY.
- Inserts preamble/SFD, pads to the minimum frame length, appends CRC-32 FCS and enforces the inter-frame gap.
- Counterpart of the RMII receive path inside the ETH com block; runs in the 50 MHz RMII clock domain.

Parameters:
- PARAM_PREAMBLE_BYTES, 7: count of 0x55 bytes sent before the SFD (0xD5).
- PARAM_IFG_BYTES, 12: inter-frame gap in byte times (4 clk each) with eth_tx_en low.
- PARAM_MIN_FRAME, 60: minimum payload+header bytes before the FCS; pad target.

Ports:
- clk  in  1  50 MHz RMII reference clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  8  frame byte (dst MAC first, FCS excluded).
- tx_valid  in  1  tx_data valid.
- tx_last  in  1  marks the final byte of the frame.
- tx_ready  out  1  byte accepted when tx_valid & tx_ready.
- eth_tx_en  out  1  RMII TX_EN.
- eth_tx_data  out  2  RMII TXD, LSB dibit first.
- tx_busy  out  1  high in every state except IDLE.
- tx_underrun  out  1  one-cycle pulse on an aborted frame.

Behaviour:
- Reset: all outputs are 0; state is IDLE; CRC is 0xFFFFFFFF; counters are 0. Reset is asynchronous, so eth_tx_en drops immediately even mid-frame. After release the block is in IDLE with no IFG pending.
- Each byte is sent as 4 dibits, bits [1:0] first through [7:6]. A 2-bit dibit counter (dc) wraps 3→0.
- State machine:
  - IDLE: waits for tx_valid=1, then goes to PRE at the next edge. No byte is consumed.
  - PRE: sends PARAM_PREAMBLE_BYTES × 0x55, then goes to SFD.
  - SFD: sends 0xD5. On dc==3, tx_ready=1 and the first data byte is latched, then go to DATA. If tx_valid=0 at that point → ABORT.
  - DATA: sends the latched byte and updates the CRC per dibit. On dc==3:
    - last byte already latched → go to PAD if byte count < PARAM_MIN_FRAME, else FCS.
    - otherwise tx_ready=1 and the next byte is latched; tx_valid=0 → ABORT.
  - PAD: sends 0x00 bytes (included in the CRC) until the count reaches PARAM_MIN_FRAME, then goes to FCS.
  - FCS: sends ~CRC over 4 bytes, LSB first, then goes to IFG.
  - ABORT: eth_tx_en goes low at the next edge and tx_underrun pulses for one cycle. No FCS is sent. Go to IFG.
  - IFG: eth_tx_en stays low for PARAM_IFG_BYTES×4 cycles, then returns to IDLE. tx_ready=0 throughout.
- tx_ready is combinational from state/dc and is high only in the accept cycles above. A tx_last seen outside a transfer is ignored.
- eth_tx_en and eth_tx_data are registered. eth_tx_en first rises 2 clk after tx_valid is sampled high in IDLE. It stays high for exactly (PRE+1+max(N,MIN)+4)×4 cycles, where N is the number of bytes accepted.
- CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated 2 bits per clk over data and pad only. It is reinitialised in IDLE.
- Byte counter is 11 bits and saturates at 2047. There is no maximum frame length check.
- A tx_valid held high continuously produces back-to-back frames separated by exactly one IFG.

Optional Feature:
- PCILEECH_ETH_TX_PAD_EN
  - Defined: PAD state active as described.
  - Undefined: PAD state is removed; DATA goes directly to FCS after the last byte. Short frames are sent unpadded, and the caller is responsible for padding.

Decomposition:
- Package pcileech_eth_pkg holds:
  - state enum typedef.
  - constants: ETH_PREAMBLE_BYTE 0x55, ETH_SFD_BYTE 0xD5, ETH_CRC32_POLY 0xEDB88320, ETH_CRC32_INIT 0xFFFFFFFF.
  - function crc32_dibit(crc, d[1:0]).
- One sub-module: pcileech_eth_crc32_d2. It is the registered 2-bit-per-cycle CRC engine with init/enable ports, and the RX path reuses it.

Test Plan:
- Single 60-byte frame (bytes 0x00..0x3B, last on 0x3B): eth_tx_en high for 288 cycles; dibits decode to 7×0x55, 0xD5, the payload, then an FCS equal to the software CRC-32. tx_ready pulses 60 times, 4 clk apart.
- 14-byte frame with PAD_EN defined: 46 zero pad bytes follow, eth_tx_en lasts 288 cycles, and the FCS covers the pad. With PAD_EN undefined, eth_tx_en lasts 104 cycles.
- Back-to-back frames with tx_valid held high: eth_tx_en is low for exactly 48 cycles between frames, and the second preamble is intact.
- Underrun (tx_valid dropped before byte 20 of 60): eth_tx_en falls within 1 clk, tx_underrun is a one-cycle pulse, no FCS is emitted, then there are 48 low cycles and the block returns to IDLE.
- rst_n asserted mid-DATA: eth_tx_en, tx_busy and tx_ready go to 0 asynchronously. After release, a new frame starts cleanly with CRC init 0xFFFFFFFF and a correct FCS.
- Known vector "123456789" (9 bytes, PAD_EN undefined): the transmitted FCS, read LSB first, equals 0xCBF43926.
